store_controller: RTL and testbench



---
 rtl/gemm_pkg.sv | 15 +
 rtl/store_controller.sv | 142 ++++++++++++++
 tb/tb_store_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared GEMM accelerator types.
// Store FSM states and memory read/write encoding.
package gemm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PRIME = 2'd2,
        ST_WRITE = 2'd3
    } store_state_t;

    localparam logic RDWR_RD = 1'b0;
    localparam logic RDWR_WR = 1'b1;

endpackage

// File: rtl/store_controller.sv
// Write-back engine: drains the accumulator one row per cycle
// and issues row-addressed write requests into tile C.
module store_controller
    import gemm_pkg::*;
#(
    parameter int DRAIN_LAT = 2,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              can_store,
    input  logic [ADDR_W-1:0] tile_C_addr,
    input  logic [ADDR_W-1:0] tile_C_stride,
    input  logic [4:0]        msize,
    input  logic [4:0]        nsize,
    output logic              gen_addr_store,
    output logic [ADDR_W-1:0] next_row_addr_store,
    output logic              interface_en_store,
    output logic              interface_rdwr_store,
    output logic [4:0]        interface_control_store,
    output logic              accum_rd_en,
    output logic [4:0]        accum_rd_row,
    output logic              done_store
);

    localparam logic [3:0] LP_DRAIN = 4'(DRAIN_LAT);

    store_state_t      r_state;
    logic [3:0]        r_cnt;
    logic [4:0]        r_row;
    logic [4:0]        r_msize;
    logic [4:0]        r_nsize;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;

    logic              w_last;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_last      = (r_row == r_msize - 5'd1);
    assign w_addr_next = r_addr + r_stride;

    // r_addr holds the address of the row being written this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_row    <= '0;
            r_msize  <= '0;
            r_nsize  <= '0;
            r_addr   <= '0;
            r_stride <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (can_store) begin
                        r_addr   <= tile_C_addr;
                        r_stride <= tile_C_stride;
                        r_msize  <= msize;
                        r_nsize  <= nsize;
                        r_row    <= '0;
                        r_cnt    <= LP_DRAIN;
                        if (DRAIN_LAT == 0) begin
                            r_state <= ST_PRIME;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!can_store) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt <= 4'd1) begin
                        r_state <= ST_PRIME;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_PRIME: begin
                    if (!can_store || r_msize == 5'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WRITE;
                        r_row   <= '0;
                    end
                end
                ST_WRITE: begin
                    if (!can_store || w_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_row  <= r_row + 5'd1;
                        r_addr <= w_addr_next;
                    end
                end
            endcase
        end
    end

    // Outputs are a decode of state gated by can_store, so an abort
    // or reset cycle shows all-zero outputs without extra delay.
    always_comb begin
        gen_addr_store          = 1'b0;
        next_row_addr_store     = '0;
        interface_en_store      = 1'b0;
        interface_rdwr_store    = RDWR_RD;
        interface_control_store = '0;
        accum_rd_en             = 1'b0;
        accum_rd_row            = '0;
        done_store              = 1'b0;
        if (!rst && can_store) begin
            unique case (r_state)
                ST_IDLE: begin
                    gen_addr_store      = 1'b1;
                    next_row_addr_store = tile_C_addr;
                end
                ST_DRAIN: begin
                end
                ST_PRIME: begin
                    if (r_msize == 5'd0) begin
                        done_store = 1'b1;
                    end else begin
                        accum_rd_en  = 1'b1;
                        accum_rd_row = '0;
                    end
                end
                ST_WRITE: begin
                    interface_en_store      = 1'b1;
                    interface_rdwr_store    = RDWR_WR;
                    interface_control_store = r_nsize;
                    if (w_last) begin
                        done_store = 1'b1;
                    end else begin
                        accum_rd_en         = 1'b1;
                        accum_rd_row        = r_row + 5'd1;
                        gen_addr_store      = 1'b1;
                        next_row_addr_store = w_addr_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_controller.sv
// Bench for store_controller: two instances (DRAIN_LAT 2 and 0)
// checked per cycle against a timeline model of the store sequence.
module tb_store_controller;

    logic        clk;
    logic        rst;
    logic        cs   [2];
    logic [31:0] caddr[2];
    logic [31:0] cstr [2];
    logic [4:0]  ms   [2];
    logic [4:0]  ns   [2];

    logic        gen  [2];
    logic [31:0] nra  [2];
    logic        en   [2];
    logic        rdwr [2];
    logic [4:0]  ctl  [2];
    logic        rde  [2];
    logic [4:0]  row  [2];
    logic        done [2];

    int dl[2] = '{2, 0};
    int vectors = 0;
    int miscompares = 0;

    store_controller #(.DRAIN_LAT(2), .ADDR_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .can_store(cs[0]),
        .tile_C_addr(caddr[0]), .tile_C_stride(cstr[0]),
        .msize(ms[0]), .nsize(ns[0]),
        .gen_addr_store(gen[0]), .next_row_addr_store(nra[0]),
        .interface_en_store(en[0]), .interface_rdwr_store(rdwr[0]),
        .interface_control_store(ctl[0]),
        .accum_rd_en(rde[0]), .accum_rd_row(row[0]),
        .done_store(done[0])
    );

    store_controller #(.DRAIN_LAT(0), .ADDR_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .can_store(cs[1]),
        .tile_C_addr(caddr[1]), .tile_C_stride(cstr[1]),
        .msize(ms[1]), .nsize(ns[1]),
        .gen_addr_store(gen[1]), .next_row_addr_store(nra[1]),
        .interface_en_store(en[1]), .interface_rdwr_store(rdwr[1]),
        .interface_control_store(ctl[1]),
        .accum_rd_en(rde[1]), .accum_rd_row(row[1]),
        .done_store(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {gen, next_addr, en, rdwr, ctrl, rd_en, rd_row, done}
    function automatic logic [46:0] model(input int d, input int m,
                                         input logic [4:0] n,
                                         input logic [31:0] c,
                                         input logic [31:0] s,
                                         input int t);
        logic        g  = 1'b0;
        logic [31:0] nx = '0;
        logic        e  = 1'b0;
        logic [4:0]  ct = '0;
        logic        r  = 1'b0;
        logic [4:0]  rw = '0;
        logic        dn = 1'b0;
        int          k;
        if (t == 0) begin
            g  = 1'b1;
            nx = c;
        end else if (t == d + 1) begin
            if (m == 0) dn = 1'b1;
            else r = 1'b1;
        end else if (t >= d + 2 && t < d + 2 + m) begin
            k  = t - d - 2;
            e  = 1'b1;
            ct = n;
            if (k < m - 1) begin
                r  = 1'b1;
                rw = 5'(k + 1);
                g  = 1'b1;
                nx = c + s * 32'(k + 1);
            end else begin
                dn = 1'b1;
            end
        end
        return {g, nx, e, e, ct, r, rw, dn};
    endfunction

    task automatic step(input logic rv, input logic c0, input logic c1,
                        input logic [46:0] e0, input logic [46:0] e1,
                        input string tag);
        logic [46:0] o0;
        logic [46:0] o1;
        @(posedge clk);
        #1;
        rst   = rv;
        cs[0] = c0;
        cs[1] = c1;
        @(negedge clk);
        o0 = {gen[0], nra[0], en[0], rdwr[0], ctl[0], rde[0], row[0], done[0]};
        o1 = {gen[1], nra[1], en[1], rdwr[1], ctl[1], rde[1], row[1], done[1]};
        vectors++;
        assert (o0 === e0) else begin
            miscompares++;
            $error("FAIL %s dut0 observed=%h expected=%h", tag, o0, e0);
        end
        vectors++;
        assert (o1 === e1) else begin
            miscompares++;
            $error("FAIL %s dut1 observed=%h expected=%h", tag, o1, e1);
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 1'b0, '0, '0, tag);
    endtask

    task automatic run_store(input int inst, input int m, input logic [4:0] n,
                             input logic [31:0] c, input logic [31:0] s,
                             input int abort_at, input int rst_at,
                             input string tag);
        int          len;
        int          d;
        logic        cv;
        logic        rv;
        logic [46:0] e;
        d           = dl[inst];
        len         = (m == 0) ? d + 2 : d + m + 2;
        caddr[inst] = c;
        cstr[inst]  = s;
        ms[inst]    = 5'(m);
        ns[inst]    = n;
        for (int t = 0; t < len; t++) begin
            cv = 1'b1;
            rv = 1'b0;
            e  = model(d, m, n, c, s, t);
            if (t == abort_at) begin
                cv = 1'b0;
                e  = '0;
            end
            if (t == rst_at) begin
                rv = 1'b1;
                e  = '0;
            end
            if (inst == 0) step(rv, cv, 1'b0, e, '0, $sformatf("%s_t%0d", tag, t));
            else           step(rv, 1'b0, cv, '0, e, $sformatf("%s_t%0d", tag, t));
            if (t == abort_at || t == rst_at) break;
        end
    endtask

    initial begin
        int m;
        int inst;
        int len;
        int ab;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cs[i]    = 1'b0;
            caddr[i] = 32'h0000_1000;
            cstr[i]  = 32'h40;
            ms[i]    = 5'd3;
            ns[i]    = 5'd4;
        end
        step(1'b1, 1'b1, 1'b1, '0, '0, "reset_cs_high");
        step(1'b1, 1'b0, 1'b0, '0, '0, "reset");
        idle("idle_after_reset");

        run_store(0, 3, 5'd4, 32'h0000_1000, 32'h40, -1, -1, "base");
        idle("base_idle");
        run_store(1, 1, 5'd7, 32'h0000_2000, 32'h80, -1, -1, "dl0_m1");
        idle("dl0_idle");
        run_store(0, 0, 5'd3, 32'h0000_3000, 32'h10, -1, -1, "m0_a");
        idle("m0_a_idle");
        run_store(1, 0, 5'd3, 32'h0000_3000, 32'h10, -1, -1, "m0_b");
        idle("m0_b_idle");
        run_store(0, 2, 5'd8, 32'hFFFF_FFC0, 32'h40, -1, -1, "wrap");
        idle("wrap_idle");

        run_store(0, 4, 5'd2, 32'h0000_4000, 32'h20, 5, -1, "abort");
        idle("abort_idle");
        run_store(0, 4, 5'd2, 32'h0000_4000, 32'h20, -1, -1, "abort_restart");
        idle("abort_restart_idle");

        run_store(0, 4, 5'd9, 32'h0000_5000, 32'h100, -1, 4, "rst_write");
        idle("rst_idle");
        run_store(0, 4, 5'd9, 32'h0000_5000, 32'h100, -1, -1, "rst_restart");

        run_store(0, 3, 5'd1, 32'h0000_6000, 32'h40, -1, -1, "b2b_first");
        run_store(0, 2, 5'd31, 32'h0000_7000, 32'h44, -1, -1, "b2b_second");
        idle("b2b_idle");
        run_store(1, 2, 5'd5, 32'h0000_8000, 32'h8, -1, -1, "b2b1_first");
        run_store(1, 3, 5'd6, 32'h0000_9000, 32'hC, -1, -1, "b2b1_second");
        idle("b2b1_idle");

        for (int i = 0; i < 30; i++) begin
            inst = int'($urandom_range(1, 0));
            m    = int'($urandom_range(8, 0));
            if (i % 7 == 3) m = 31;
            len  = (m == 0) ? dl[inst] + 2 : dl[inst] + m + 2;
            ab   = -1;
            if ($urandom_range(3, 0) == 0) ab = int'($urandom_range(len - 1, 1));
            run_store(inst, m, 5'($urandom), $urandom, $urandom, ab, -1,
                      $sformatf("rand%0d", i));
            if ($urandom_range(1, 0) == 1) idle($sformatf("rand%0d_idle", i));
        end
        idle("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
